pr_bridge: RTL
==============

# pr_bridge

Processor-to-device bridge for the multi-cycle MIPS system. It sits between the CPU's device port (`PrAddr`/`PrDOut`/`PrDIn`/`HitDEV`) and two memory-mapped peripherals: device 0 is the timer and device 1 is general I/O. It decodes the word address and sequences each access as a select/wait/acknowledge handshake with timeout. It also registers the peripheral interrupt lines onto the CPU's `HWInt` vector.

## Interface
Parameters:
- DEV0_BASE, 30'h1FC0, word address of device 0; 3-word window, byte 0x7F00–0x7F0B
- DEV1_BASE, 30'h1FC4, word address of device 1; 3-word window, byte 0x7F10–0x7F1B
- TIMEOUT, 15, maximum WAIT cycles before forced completion (1..255)

Ports (one clock; reset is synchronous and active-high, named as the codebase does):
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- PrAddr  in  30  CPU word address
- PrDOut  in  32  CPU write data
- WeCPU  in  1  write (1) / read (0) qualifier, sampled with PrReq
- PrReq  in  1  one-cycle access request from the CPU control FSM
- HitDEV  out  1  combinational: PrAddr falls in either device window
- PrDIn  out  32  read data, valid from the PrRdy cycle until the next completion
- PrRdy  out  1  one-cycle completion pulse
- BusErr  out  1  one-cycle pulse, concurrent with PrRdy, on timeout
- HWInt  out  6  registered interrupt vector to CP0
- DevAddr  out  2  latched word offset within the window (PrAddr[1:0])
- DevWD  out  32  latched write data
- DevSel0, DevSel1  out  1 each  device select
- DevWe0, DevWe1  out  1 each  device write enable
- DevRD0, DevRD1  in  32 each  device read data
- DevAck0, DevAck1  in  1 each  device acknowledge
- DevIRQ0, DevIRQ1  in  1 each  device interrupt request levels

## Operation
- Decode: a word is a hit if PrAddr − BASE is in 0..2 for either device. HitDEV = hit0 | hit1. Windows never overlap.
- States:
  - IDLE: on PrReq & HitDEV, latch target, DevAddr, DevWD and write flag, then go to ACCESS. PrReq without a hit is ignored and the bridge stays in IDLE.
  - ACCESS: assert DevSelN for exactly this cycle, and DevWeN too if the access is a write. If DevAckN is high in this cycle, capture DevRDN and go to DONE. Otherwise go to WAIT and clear the counter.
  - WAIT: hold DevSel low and wait for DevAckN of the latched target only.
    - Ack: capture DevRDN into PrDIn and go to DONE.
    - Counter reaches TIMEOUT with no ack: load PrDIn = 32'hFFFF_FFFF, set the error flag and go to DONE.
    - Otherwise increment the counter (8-bit, saturating).
  - DONE: PrRdy = 1, and BusErr = error flag. Next state is IDLE.
- Writes still require an acknowledge. On write completion PrDIn is unchanged.
- PrReq outside IDLE is ignored; the CPU stalls until PrRdy.
- Acknowledges from the non-target device, and ack in IDLE or DONE, are ignored.
- Interrupts:
  - HWInt[0] <= DevIRQ0 and HWInt[1] <= DevIRQ1 every cycle, independent of FSM state.
  - HWInt[5:2] = 0.

## Timing
- Reset values: state IDLE, counter 0, PrDIn 0, PrRdy 0, BusErr 0, HWInt 0, DevSel*/DevWe* 0, DevAddr 0, DevWD 0.
- Reset mid-access aborts immediately: no PrRdy and no select in the following cycle.
- Minimum latency:
  - PrReq at cycle 0, ACCESS/select at cycle 1.
  - Ack at cycle 1 gives PrRdy at cycle 2.
  - Ack k cycles after select gives PrRdy at cycle 2 + k.
- Timeout: with no ack, PrRdy + BusErr at cycle 2 + TIMEOUT + 1.
- Simultaneous ack and timeout in the same WAIT cycle: ack wins, no BusErr.
- HWInt lags the DevIRQ lines by one cycle.
- HitDEV has no latency (pure decode of PrAddr).
- Back-to-back requests: the earliest next accepted PrReq is the cycle after DONE. Minimum 3-cycle spacing.

## Structure
- Package `bridge_pkg`:
  - state encoding (IDLE, ACCESS, WAIT, DONE; 2 bits)
  - default base addresses
  - error word 32'hFFFF_FFFF
  - window size 3
- Sub-module `bridge_decode`: combinational window compare. It outputs hit0, hit1 and HitDEV. It is reused by the testbench address-map checker.
- Top `pr_bridge`: FSM, latch registers, counter, read-data register and interrupt register.

## Test plan
- Zero-wait read: PrAddr = 30'h1FC1, WeCPU = 0, PrReq at cycle 0, device 0 acks at cycle 1 with 32'h1234_5678 → DevSel0 = 1 only at cycle 1, DevAddr = 1, PrRdy and PrDIn = 32'h1234_5678 at cycle 2, BusErr = 0.
- Wait-state write: PrAddr = 30'h1FC4, PrDOut = 32'hA5A5_0001, WeCPU = 1, device 1 acks 4 cycles after select → DevWe1 = 1 only at cycle 1, DevWD = 32'hA5A5_0001, PrRdy at cycle 6, PrDIn unchanged.
- Timeout: request to device 0 with no ack, TIMEOUT = 15 → PrRdy = BusErr = 1 at cycle 18, PrDIn = 32'hFFFF_FFFF; a following good access returns BusErr = 0.
- Decode boundaries: PrAddr in 1FBF, 1FC0, 1FC2, 1FC3, 1FC4, 1FC6, 1FC7 → HitDEV = 0,1,1,0,1,1,0. PrReq on a miss leaves the state IDLE and no PrRdy.
- Reset and stray acks: assert reset in WAIT → all outputs 0 next cycle and no PrRdy. DevAck1 during a device-0 access is ignored (timeout still occurs). PrReq in WAIT is ignored.
- Interrupts: DevIRQ1 = 1 at cycle 5 → HWInt = 6'b000010 at cycle 6. DevIRQ1 cleared at cycle 9 → HWInt = 0 at cycle 10. Independent of concurrent bus traffic.

Source files
------------

// File: rtl/bridge_pkg.sv
// rtl/bridge_pkg.sv - shared types and constants for the processor-to-device bridge
package bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [29:0] DEF_DEV0_BASE = 30'h1FC0;
   localparam logic [29:0] DEF_DEV1_BASE = 30'h1FC4;
   localparam logic [31:0] ERR_WORD      = 32'hFFFF_FFFF;
   localparam logic [29:0] WIN_SIZE      = 30'd3;

   // Unsigned wrap makes addresses below the base land far outside the window.
   function automatic logic in_window(input logic [29:0] addr, input logic [29:0] base);
      logic [29:0] offs;
      offs = addr - base;
      return offs < WIN_SIZE;
   endfunction

endpackage

// File: rtl/bridge_decode.sv
// rtl/bridge_decode.sv - combinational word-address window compare for both devices
module bridge_decode
   import bridge_pkg::*;
#(
   parameter logic [29:0] DEV0_BASE = DEF_DEV0_BASE,
   parameter logic [29:0] DEV1_BASE = DEF_DEV1_BASE
) (
   input  logic [29:0] PrAddr,
   output logic        hit0,
   output logic        hit1,
   output logic        HitDEV
);

   assign hit0   = in_window(PrAddr, DEV0_BASE);
   assign hit1   = in_window(PrAddr, DEV1_BASE);
   assign HitDEV = hit0 | hit1;

endmodule

// File: rtl/pr_bridge.sv
// rtl/pr_bridge.sv - CPU device-port bridge: decode, select/wait/ack sequencing with timeout, IRQ register
module pr_bridge
   import bridge_pkg::*;
#(
   parameter logic [29:0] DEV0_BASE = DEF_DEV0_BASE,
   parameter logic [29:0] DEV1_BASE = DEF_DEV1_BASE,
   parameter int          TIMEOUT   = 15
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [29:0] PrAddr,
   input  logic [31:0] PrDOut,
   input  logic        WeCPU,
   input  logic        PrReq,
   output logic        HitDEV,
   output logic [31:0] PrDIn,
   output logic        PrRdy,
   output logic        BusErr,
   output logic [5:0]  HWInt,
   output logic [1:0]  DevAddr,
   output logic [31:0] DevWD,
   output logic        DevSel0,
   output logic        DevSel1,
   output logic        DevWe0,
   output logic        DevWe1,
   input  logic [31:0] DevRD0,
   input  logic [31:0] DevRD1,
   input  logic        DevAck0,
   input  logic        DevAck1,
   input  logic        DevIRQ0,
   input  logic        DevIRQ1
);

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   state_t      state;
   state_t      state_nxt;
   logic        hit0;
   logic        hit1;
   logic        accept;
   logic        tgt;        // 0 = timer, 1 = general I/O
   logic        wr;
   logic        err_flag;
   logic [7:0]  cnt;
   logic        ack_tgt;
   logic [31:0] rd_tgt;

   bridge_decode #(
      .DEV0_BASE(DEV0_BASE),
      .DEV1_BASE(DEV1_BASE)
   ) u_decode (
      .PrAddr(PrAddr),
      .hit0  (hit0),
      .hit1  (hit1),
      .HitDEV(HitDEV)
   );

   assign accept  = (state == ST_IDLE) & PrReq & (hit0 | hit1);
   // Only the latched target's handshake is ever observed.
   assign ack_tgt = tgt ? DevAck1 : DevAck0;
   assign rd_tgt  = tgt ? DevRD1  : DevRD0;

   // State register.
   always_ff @(posedge clock) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next-state: ack beats timeout when both land in the same WAIT cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (accept) state_nxt = ST_ACCESS;
         ST_ACCESS: state_nxt = ack_tgt ? ST_DONE : ST_WAIT;
         ST_WAIT:   if (ack_tgt || cnt == TIMEOUT_CNT) state_nxt = ST_DONE;
         ST_DONE:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Outputs: select strobes for the single ACCESS cycle, completion in DONE.
   always_comb begin
      DevSel0 = (state == ST_ACCESS) & ~tgt;
      DevSel1 = (state == ST_ACCESS) &  tgt;
      DevWe0  = DevSel0 & wr;
      DevWe1  = DevSel1 & wr;
      PrRdy   = (state == ST_DONE);
      BusErr  = (state == ST_DONE) & err_flag;
   end

   // Request latches, wait counter and read-data capture.
   always_ff @(posedge clock) begin
      if (reset) begin
         tgt      <= 1'b0;
         wr       <= 1'b0;
         err_flag <= 1'b0;
         cnt      <= 8'd0;
         DevAddr  <= 2'd0;
         DevWD    <= 32'd0;
         PrDIn    <= 32'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  tgt      <= hit1;
                  wr       <= WeCPU;
                  err_flag <= 1'b0;
                  DevAddr  <= PrAddr[1:0];
                  DevWD    <= PrDOut;
               end
            end
            ST_ACCESS: begin
               cnt <= 8'd0;
               if (ack_tgt && !wr) PrDIn <= rd_tgt;
            end
            ST_WAIT: begin
               if (ack_tgt) begin
                  if (!wr) PrDIn <= rd_tgt;
               end else if (cnt == TIMEOUT_CNT) begin
                  PrDIn    <= ERR_WORD;
                  err_flag <= 1'b1;
               end else if (cnt != 8'hFF) begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Interrupt lines are registered every cycle regardless of bus activity.
   always_ff @(posedge clock) begin
      if (reset) HWInt <= 6'd0;
      else       HWInt <= {4'd0, DevIRQ1, DevIRQ0};
   end

endmodule
